ps2_move_ctrl: RTL and testbench

Sits between the PS/2 byte receiver and the 2048 game core. It parses the scancode byte stream and resolves the E0/F0 prefixes, make/break and typematic repeat. Recognised key presses become one-shot move commands, which are queued in a small FIFO. The game core consumes them over a valid/ready handshake, so no keypress is lost while a board shift is in progress.

---
 rtl/ps2_move_ctrl_pkg.sv | 68 ++++++
 rtl/ps2_move_ctrl_if.sv | 11 +
 rtl/move_fifo.sv | 54 +++++
 rtl/ps2_move_ctrl.sv | 138 +++++++++++++
 tb/tb_ps2_move_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_move_ctrl_pkg.sv
// Shared scancodes, direction encoding and parser state type for the PS/2 move controller.
package ps2_move_pkg;

   localparam logic [7:0] ScBreak = 8'hF0;
   localparam logic [7:0] ScExt   = 8'hE0;
   localparam logic [7:0] ScBat   = 8'hAA;
   localparam logic [7:0] ScErrFc = 8'hFC;
   localparam logic [7:0] ScErr00 = 8'h00;
   localparam logic [7:0] ScErrFf = 8'hFF;

   localparam logic [7:0] ScW = 8'h1D;
   localparam logic [7:0] ScS = 8'h1B;
   localparam logic [7:0] ScA = 8'h1C;
   localparam logic [7:0] ScD = 8'h23;
   localparam logic [7:0] ScR = 8'h2D;

   localparam logic [7:0] ScUp    = 8'h75;
   localparam logic [7:0] ScDown  = 8'h72;
   localparam logic [7:0] ScLeft  = 8'h6B;
   localparam logic [7:0] ScRight = 8'h74;

   typedef logic [1:0] dir_t;
   localparam dir_t DirUp    = 2'd0;
   localparam dir_t DirDown  = 2'd1;
   localparam dir_t DirLeft  = 2'd2;
   localparam dir_t DirRight = 2'd3;

   typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_t;

   typedef struct packed {
      logic hit;
      dir_t dir;
   } key_t;

   function automatic logic is_err_byte(logic [7:0] b);
      return (b == ScErrFc) || (b == ScErr00) || (b == ScErrFf);
   endfunction

   function automatic key_t map_plain(logic [7:0] b);
      key_t k;
      k.hit = 1'b1;
      k.dir = DirUp;
      case (b)
         ScW:     k.dir = DirUp;
         ScS:     k.dir = DirDown;
         ScA:     k.dir = DirLeft;
         ScD:     k.dir = DirRight;
         ScBat:   k.hit = 1'b0;
         default: k.hit = 1'b0;
      endcase
      return k;
   endfunction

   function automatic key_t map_ext(logic [7:0] b);
      key_t k;
      k.hit = 1'b1;
      k.dir = DirUp;
      case (b)
         ScUp:    k.dir = DirUp;
         ScDown:  k.dir = DirDown;
         ScLeft:  k.dir = DirLeft;
         ScRight: k.dir = DirRight;
         default: k.hit = 1'b0;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/ps2_move_ctrl_if.sv
// Move command handshake between the keyboard controller (master) and the game core (slave).
interface ps2_move_ctrl_if;
   import ps2_move_pkg::*;

   logic move_valid;
   dir_t move_dir;
   logic move_ready;

   modport master (output move_valid, output move_dir, input move_ready);
   modport slave  (input move_valid, input move_dir, output move_ready);
endinterface

// File: rtl/move_fifo.sv
// Small move-command FIFO with flush, explicit level counter and same-cycle push/pop.
module move_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 2,
   localparam int unsigned LW = $clog2(DEPTH) + 1,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic             valid,
   output logic [WIDTH-1:0] head,
   output logic [LW-1:0]    level,
   output logic             overflow
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [LW-1:0]    level_q;
   logic             full, do_push, do_pop;

   assign valid    = (level_q != '0);
   assign full     = (level_q == LW'(DEPTH));
   assign do_pop   = pop & valid;
   // A full queue still accepts a push when the head leaves on the same edge.
   assign do_push  = push & (~full | do_pop);
   assign overflow = push & full & ~do_pop;
   assign head     = valid ? mem_q[rptr_q] : '0;
   assign level    = level_q;

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wptr_q] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/ps2_move_ctrl.sv
// PS/2 scancode parser: resolves E0/F0 prefixes and typematic repeat into queued move commands.
module ps2_move_ctrl
   import ps2_move_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 250000,
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1,
   localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
   input  logic                 clk25,
   input  logic                 rst,
   input  logic [7:0]           rx_byte,
   input  logic                 rx_valid,
   ps2_move_ctrl_if.master      mv,
   output logic                 restart_pulse,
   output logic                 kb_error,
   output logic [LW-1:0]        fifo_level
);

   state_t         state_q, state_d;
   logic [CW-1:0]  tmo_q;
   logic [3:0]     held_q, held_d;
   logic           r_held_q, r_held_d;
   logic           restart_q, restart_d;
   logic           err_q;
   logic           timeout, err_byte, overflow;
   logic           push, flush;
   dir_t           push_dir;
   key_t           plain_k, ext_k;

   assign plain_k  = map_plain(rx_byte);
   assign ext_k    = map_ext(rx_byte);
   assign err_byte = rx_valid & is_err_byte(rx_byte);
   assign timeout  = (state_q != StIdle) && !rx_valid && (tmo_q == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk25) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (timeout) begin
         state_d = StIdle;
      end else if (rx_valid) begin
         if (err_byte) begin
            state_d = StIdle;
         end else begin
            unique case (state_q)
               StIdle:   state_d = (rx_byte == ScBreak) ? StBrk :
                                   (rx_byte == ScExt)   ? StExt : StIdle;
               StBrk:    state_d = StIdle;
               StExt:    state_d = (rx_byte == ScBreak) ? StExtBrk : StIdle;
               StExtBrk: state_d = StIdle;
            endcase
         end
      end
   end

   always_comb begin
      held_d    = held_q;
      r_held_d  = r_held_q;
      push      = 1'b0;
      push_dir  = plain_k.dir;
      flush     = 1'b0;
      restart_d = 1'b0;
      if (rx_valid && !err_byte) begin
         unique case (state_q)
            StIdle: begin
               if (plain_k.hit) begin
                  push             = ~held_q[plain_k.dir];
                  held_d[plain_k.dir] = 1'b1;
               end else if (rx_byte == ScR && !r_held_q) begin
                  flush     = 1'b1;
                  restart_d = 1'b1;
                  r_held_d  = 1'b1;
               end
            end
            StBrk: begin
               if (plain_k.hit)         held_d[plain_k.dir] = 1'b0;
               else if (rx_byte == ScR) r_held_d = 1'b0;
            end
            StExt: begin
               if (ext_k.hit) begin
                  push_dir          = ext_k.dir;
                  push              = ~held_q[ext_k.dir];
                  held_d[ext_k.dir] = 1'b1;
               end
            end
            StExtBrk: begin
               if (ext_k.hit) held_d[ext_k.dir] = 1'b0;
            end
         endcase
      end
      if (err_byte) begin
         held_d   = '0;
         r_held_d = 1'b0;
      end
   end

   always_ff @(posedge clk25) begin
      if (rst) begin
         tmo_q     <= '0;
         held_q    <= '0;
         r_held_q  <= 1'b0;
         restart_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // Counter idles at zero in StIdle and restarts on every received byte.
         if (rx_valid || state_q == StIdle || timeout) tmo_q <= '0;
         else                                          tmo_q <= tmo_q + CW'(1);
         held_q    <= held_d;
         r_held_q  <= r_held_d;
         restart_q <= restart_d;
         err_q     <= err_byte | timeout | overflow;
      end
   end

   assign restart_pulse = restart_q;
   assign kb_error      = err_q;

   move_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2)
   ) u_fifo (
      .clk       (clk25),
      .rst       (rst),
      .push      (push),
      .push_data (push_dir),
      .pop       (mv.move_ready),
      .flush     (flush),
      .valid     (mv.move_valid),
      .head      (mv.move_dir),
      .level     (fifo_level),
      .overflow  (overflow)
   );

endmodule

// File: tb/tb_ps2_move_ctrl.sv
// Scoreboard bench: expected queue contents follow the stimulus and are checked as moves are accepted.
module tb_ps2_move_ctrl;

   localparam int unsigned Depth = 4;
   localparam int unsigned Tmo   = 64;

   logic       clk25 = 1'b0;
   logic       rst;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       restart_pulse, kb_error;
   logic [2:0] fifo_level;

   int n_total = 0;
   int n_bad   = 0;
   logic [1:0] sb[$];

   ps2_move_ctrl_if mif ();

   ps2_move_ctrl #(
      .FIFO_DEPTH  (Depth),
      .TIMEOUT_CYC (Tmo)
   ) dut (
      .clk25         (clk25),
      .rst           (rst),
      .rx_byte       (rx_byte),
      .rx_valid      (rx_valid),
      .mv            (mif),
      .restart_pulse (restart_pulse),
      .kb_error      (kb_error),
      .fifo_level    (fifo_level)
   );

   always #5 clk25 = ~clk25;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called just after a rising edge; advances one clock and updates the expected queue.
   task automatic step(input bit push_exp, input logic [1:0] pdir, input bit flush_exp,
                       input bit err_exp);
      bit pop_now;
      bit full;
      bit ovf;
      ovf = 1'b0;
      check("level", 32'(fifo_level), 32'(sb.size()));
      check("valid", 32'(mif.move_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) check("head", 32'(mif.move_dir), 32'(sb[0]));
      pop_now = (sb.size() != 0) && mif.move_ready;
      full    = (sb.size() == Depth);
      @(posedge clk25);
      #1;
      if (flush_exp) begin
         sb.delete();
      end else begin
         if (pop_now) void'(sb.pop_front());
         if (push_exp) begin
            if (!full || pop_now) sb.push_back(pdir);
            else                  ovf = 1'b1;
         end
      end
      rx_valid = 1'b0;
      check("kb_error", 32'(kb_error), 32'(err_exp | ovf));
      check("restart", 32'(restart_pulse), 32'(flush_exp));
   endtask

   task automatic send(input logic [7:0] b, input bit push_exp, input logic [1:0] pdir,
                       input bit flush_exp, input bit err_exp);
      rx_byte  = b;
      rx_valid = 1'b1;
      step(push_exp, pdir, flush_exp, err_exp);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic plain(input logic [7:0] b);
      send(b, 1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      @(posedge clk25);
      @(posedge clk25);
      #1;
      rst = 1'b0;
      sb.delete();
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_valid", 32'(mif.move_valid), 32'd0);
      check("rst_dir", 32'(mif.move_dir), 32'd0);
      check("rst_err", 32'(kb_error), 32'd0);
      check("rst_restart", 32'(restart_pulse), 32'd0);
   endtask

   initial begin
      mif.move_ready = 1'b0;
      do_reset();

      // Single make then release: one entry, release pushes nothing.
      send(8'h1D, 1'b1, 2'd0, 1'b0, 1'b0);
      check("t1_level", 32'(fifo_level), 32'd1);
      check("t1_dir", 32'(mif.move_dir), 32'd0);
      plain(8'hF0);
      plain(8'h1D);
      mif.move_ready = 1'b1;
      idle(2);
      mif.move_ready = 1'b0;

      // Typematic arrow repeats collapse to one entry per press.
      plain(8'hE0); send(8'h74, 1'b1, 2'd3, 1'b0, 1'b0);
      plain(8'hE0); plain(8'h74);
      plain(8'hE0); plain(8'h74);
      plain(8'hE0); plain(8'hF0); plain(8'h74);
      plain(8'hE0); send(8'h74, 1'b1, 2'd3, 1'b0, 1'b0);
      check("t2_level", 32'(fifo_level), 32'd2);
      plain(8'hE0); plain(8'hF0); plain(8'h74);
      mif.move_ready = 1'b1;
      idle(3);
      mif.move_ready = 1'b0;

      // Fill to depth, then overflow.
      send(8'h1D, 1'b1, 2'd0, 1'b0, 1'b0);
      send(8'h1B, 1'b1, 2'd1, 1'b0, 1'b0);
      send(8'h1C, 1'b1, 2'd2, 1'b0, 1'b0);
      send(8'h23, 1'b1, 2'd3, 1'b0, 1'b0);
      plain(8'hF0); plain(8'h1D);
      send(8'h1D, 1'b1, 2'd0, 1'b0, 1'b1);
      check("t3_level", 32'(fifo_level), 32'd4);
      plain(8'hF0); plain(8'h1D);

      // Full queue with simultaneous push and pop.
      mif.move_ready = 1'b1;
      send(8'h1D, 1'b1, 2'd0, 1'b0, 1'b0);
      check("t4_level", 32'(fifo_level), 32'd4);
      check("t4_head", 32'(mif.move_dir), 32'd1);
      idle(5);
      mif.move_ready = 1'b0;
      plain(8'hF0); plain(8'h1B);
      plain(8'hF0); plain(8'h1C);
      plain(8'hF0); plain(8'h23);
      plain(8'hF0); plain(8'h1D);

      // Prefix timeout returns to idle; 6B is then an unmapped plain code.
      plain(8'hE0);
      idle(Tmo - 1);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      idle(1);
      plain(8'h6B);
      idle(1);

      // Restart flushes the queue, coincident pop accepted.
      send(8'h1D, 1'b1, 2'd0, 1'b0, 1'b0);
      send(8'h1B, 1'b1, 2'd1, 1'b0, 1'b0);
      send(8'h1C, 1'b1, 2'd2, 1'b0, 1'b0);
      mif.move_ready = 1'b1;
      send(8'h2D, 1'b0, 2'd0, 1'b1, 1'b0);
      check("t6_level", 32'(fifo_level), 32'd0);
      check("t6_valid", 32'(mif.move_valid), 32'd0);
      idle(1);
      plain(8'h2D);
      plain(8'hF0); plain(8'h2D);
      send(8'h2D, 1'b0, 2'd0, 1'b1, 1'b0);
      mif.move_ready = 1'b0;

      // Error bytes clear held keys without touching the queue.
      plain(8'hE0); plain(8'hF0);
      send(8'hFC, 1'b0, 2'd0, 1'b0, 1'b1);
      send(8'h1D, 1'b1, 2'd0, 1'b0, 1'b0);
      send(8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
      check("t7_level", 32'(fifo_level), 32'd1);
      send(8'h1B, 1'b1, 2'd1, 1'b0, 1'b0);
      mif.move_ready = 1'b1;
      idle(3);
      mif.move_ready = 1'b0;

      // Reset mid-prefix; next byte parsed fresh.
      plain(8'hE0); plain(8'hF0);
      do_reset();
      plain(8'h74);
      plain(8'hAA);
      mif.move_ready = 1'b1;
      send(8'h1B, 1'b1, 2'd1, 1'b0, 1'b0);
      check("t8_level", 32'(fifo_level), 32'd1);
      idle(2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
